d_term_pipe: RTL and testbench
==============================

Name: d_term_pipe

Overview:
Parametrised, pipelined derivative-term generator for the PID controller. It takes saturated error samples qualified by err_vld and forms err[n] − err[n−SPAN] at full precision without wrap-around. The difference is saturated to DIFF_W bits and multiplied by a runtime-programmable signed coefficient. The result goes to the PID summer with an explicit valid strobe; D_term is the product bus.

Parameters:
ERR_W, 11, width of signed error input
SPAN, 2, derivative span in valid samples (≥1)
DIFF_W, 8, signed width of saturated difference
COEFF_W, 7, signed width of coefficient
COEFF_RST, 7'h38, coefficient value after reset/clr (signed, +56)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
err_sat  in  ERR_W  signed saturated error sample
err_vld  in  1  error sample valid this cycle
clr  in  1  synchronous flush (history, pipeline, coeff)
coeff_wr  in  1  load coeff_in into coefficient register
coeff_in  in  COEFF_W  signed new coefficient
D_term  out  DIFF_W+COEFF_W  signed registered derivative term
D_vld  out  1  one-cycle strobe: D_term updated this cycle
hist_full  out  1  SPAN valid samples captured since reset/clr

Behaviour:
- Reset (rst_n low, async): history regs = 0, fill count = 0, stage regs = 0, coefficient = COEFF_RST, D_term = 0, D_vld = 0, hist_full = 0.
- History: SPAN-deep shift register, advances only on err_vld. On each err_vld, err_sat enters and the oldest entry is the subtrahend for the current sample. Entries not yet filled read as 0.
- Fill counter: saturating 0..SPAN, increments on each err_vld. hist_full = (count == SPAN), registered.
- Stage 1 (cycle after err_vld): diff = sign-extended err_sat − oldest history, computed in ERR_W+1 bits with no wrap.
  - diff > 2^(DIFF_W−1)−1 → saturate to max positive (8'h7F default).
  - diff < −2^(DIFF_W−1) → saturate to max negative (8'h80 default).
  - Otherwise keep the low DIFF_W bits.
  - Stage-1 valid = registered err_vld.
- Stage 2: D_term <= signed(diff_sat) × signed(coefficient), full DIFF_W+COEFF_W width. D_vld = registered stage-1 valid.
- Latency: err_vld in cycle N → D_vld high in cycle N+2. Throughput is one sample per cycle; back-to-back err_vld is supported.
- D_term holds its last value when D_vld is low.
- Coefficient:
  - coeff_wr loads coeff_in at the clock edge.
  - A multiply in the same cycle as coeff_wr uses the old coefficient.
  - The new value applies from the next cycle.
- clr (sync):
  - Zeroes history, fill count, hist_full, stage valids, D_term and D_vld.
  - Restores coefficient to COEFF_RST.
  - In-flight samples are dropped.
  - clr has priority over err_vld and coeff_wr in the same cycle; that err_vld sample is discarded.
- rst_n asserted mid-pipeline: everything returns to reset values immediately; no D_vld for in-flight samples.
- Only the saturation boundary may change the diff value; the product never overflows the D_term width.

Test Plan:
- Reset, then err_sat = 10, 20, 30 on three consecutive err_vld cycles (defaults) → D_vld at N+2, N+3, N+4. D_term = 560, 1120, 1120. hist_full rises after the 2nd sample.
- History holds across gaps: err_vld = 0 for 5 cycles between samples → no D_vld, D_term held, history unchanged. The next sample's diff uses the correct SPAN-back value.
- Positive overflow: history 2-back = −1024, err_sat = 1023 (diff +2047, no wrap) → D_term = 127×56 = 7112 (15'h1BC8).
- Negative overflow: history 2-back = 1000, err_sat = −1000 → D_term = −128×56 = −7168 (15'h6400).
- Coefficient update:
  - coeff_wr with coeff_in = 7'h7F (−1) in the same cycle stage 2 multiplies diff 10 → that output = 560 (old coefficient).
  - The next diff of 10 → D_term = −10 (15'h7FF6).
- clr in the cycle after err_vld, with another err_vld coincident with clr:
  - No D_vld follows; D_term = 0; hist_full = 0; coefficient = 7'h38.
  - The next sample of 10 → D_term = 560.
  - Repeat with rst_n pulsed mid-pipeline → same reset values.

Source files
------------

// File: rtl/d_term_pipe.sv
// d_term_pipe: pipelined derivative term for the PID controller.
// Stage 1 forms err[n] - err[n-SPAN] without wrap and saturates it to
// DIFF_W bits. Stage 2 multiplies by a programmable signed coefficient.
module d_term_pipe #(
  parameter int                 ERR_W     = 11,
  parameter int                 SPAN      = 2,
  parameter int                 DIFF_W    = 8,
  parameter int                 COEFF_W   = 7,
  parameter logic [COEFF_W-1:0] COEFF_RST = 7'h38
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic signed [ERR_W-1:0]           err_sat,
  input  logic                              err_vld,
  input  logic                              clr,
  input  logic                              coeff_wr,
  input  logic signed [COEFF_W-1:0]         coeff_in,
  output logic signed [DIFF_W+COEFF_W-1:0]  D_term,
  output logic                              D_vld,
  output logic                              hist_full
);

  localparam int PROD_W = DIFF_W + COEFF_W;
  localparam int CNT_W  = $clog2(SPAN + 1);

  // Clamp the ERR_W+1 bit difference into DIFF_W bits. The value fits when
  // every bit from the sign bit down to bit DIFF_W-1 agrees.
  function automatic logic [DIFF_W-1:0] sat_diff(input logic [ERR_W:0] d);
    logic [ERR_W-DIFF_W+1:0] top;
    top = d[ERR_W:DIFF_W-1];
    if ((top == '0) || (top == '1)) begin
      sat_diff = d[DIFF_W-1:0];
    end else if (d[ERR_W]) begin
      sat_diff = {1'b1, {(DIFF_W-1){1'b0}}};
    end else begin
      sat_diff = {1'b0, {(DIFF_W-1){1'b1}}};
    end
  endfunction

  // Index 0 holds the newest sample; index SPAN-1 holds the oldest one.
  logic [ERR_W-1:0]         r_hist [SPAN];
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_full;
  logic [COEFF_W-1:0]       r_coeff;
  logic [DIFF_W-1:0]        r_s1_diff;
  logic                     r_s1_vld;
  logic signed [PROD_W-1:0] r_dterm;
  logic                     r_dvld;

  logic [ERR_W-1:0]         w_oldest;
  logic [ERR_W:0]           w_diff;
  logic signed [PROD_W-1:0] w_diff_x;
  logic signed [PROD_W-1:0] w_coeff_x;
  logic signed [PROD_W-1:0] w_prod;

  assign w_oldest  = r_hist[SPAN-1];
  // One extra bit keeps the difference of two ERR_W values free of wrap.
  assign w_diff    = {err_sat[ERR_W-1], err_sat} - {w_oldest[ERR_W-1], w_oldest};
  // Both operands are sign-extended to the product width, so the low PROD_W
  // bits of the product are the exact signed result (it cannot overflow).
  assign w_diff_x  = {{COEFF_W{r_s1_diff[DIFF_W-1]}}, r_s1_diff};
  assign w_coeff_x = {{DIFF_W{r_coeff[COEFF_W-1]}}, r_coeff};
  assign w_prod    = w_diff_x * w_coeff_x;

  // History shift register, advancing only on valid samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SPAN; i++) r_hist[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < SPAN; i++) r_hist[i] <= '0;
    end else if (err_vld) begin
      r_hist[0] <= err_sat;
      for (int i = 1; i < SPAN; i++) r_hist[i] <= r_hist[i-1];
    end
  end

  // Saturating fill counter and its registered "history full" flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else if (err_vld) begin
      if (r_cnt != CNT_W'(SPAN)) r_cnt <= r_cnt + CNT_W'(1);
      r_full <= (r_cnt >= CNT_W'(SPAN - 1));
    end
  end

  // Coefficient register; a same-cycle multiply still sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coeff <= COEFF_RST;
    end else if (clr) begin
      r_coeff <= COEFF_RST;
    end else if (coeff_wr) begin
      r_coeff <= coeff_in;
    end
  end

  // Stage 1: capture the saturated difference alongside its valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_diff <= '0;
      r_s1_vld  <= 1'b0;
    end else if (clr) begin
      r_s1_diff <= '0;
      r_s1_vld  <= 1'b0;
    end else begin
      r_s1_vld <= err_vld;
      if (err_vld) r_s1_diff <= sat_diff(w_diff);
    end
  end

  // Stage 2: multiply; D_term holds its value between valid results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dterm <= '0;
      r_dvld  <= 1'b0;
    end else if (clr) begin
      r_dterm <= '0;
      r_dvld  <= 1'b0;
    end else begin
      r_dvld <= r_s1_vld;
      if (r_s1_vld) r_dterm <= w_prod;
    end
  end

  assign D_term    = r_dterm;
  assign D_vld     = r_dvld;
  assign hist_full = r_full;

endmodule

// File: tb/tb_d_term_pipe.sv
// Directed self-checking bench for d_term_pipe (default parameters).
module tb_d_term_pipe;

  logic               clk;
  logic               rst_n;
  logic signed [10:0] err_sat;
  logic               err_vld;
  logic               clr;
  logic               coeff_wr;
  logic signed [6:0]  coeff_in;
  logic signed [14:0] D_term;
  logic               D_vld;
  logic               hist_full;

  int n_pass  = 0;
  int n_total = 0;

  d_term_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .err_sat   (err_sat),
    .err_vld   (err_vld),
    .clr       (clr),
    .coeff_wr  (coeff_wr),
    .coeff_in  (coeff_in),
    .D_term    (D_term),
    .D_vld     (D_vld),
    .hist_full (hist_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one valid sample for a single cycle.
  task automatic push(input int v);
    err_sat = 11'(v);
    err_vld = 1'b1;
    tick();
    err_vld = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; err_sat = '0; err_vld = 1'b0; clr = 1'b0;
    coeff_wr = 1'b0; coeff_in = '0;
    tick(); tick();
    n_total++; if (D_term !== 15'h0000) $display("FAIL reset_dterm got %h want 0000", D_term); else n_pass++;
    n_total++; if (D_vld !== 1'b0) $display("FAIL reset_dvld got %b want 0", D_vld); else n_pass++;
    n_total++; if (hist_full !== 1'b0) $display("FAIL reset_full got %b want 0", hist_full); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    push(10);
    n_total++; if (D_vld !== 1'b0) $display("FAIL basic_lat1 D_vld got %b want 0", D_vld); else n_pass++;
    n_total++; if (hist_full !== 1'b0) $display("FAIL basic_full1 got %b want 0", hist_full); else n_pass++;
    push(20);
    n_total++; if (D_vld !== 1'b1) $display("FAIL basic_lat2 D_vld got %b want 1", D_vld); else n_pass++;
    n_total++; if (D_term !== 15'h0230) $display("FAIL basic_s0 got %h want 0230", D_term); else n_pass++;
    n_total++; if (hist_full !== 1'b1) $display("FAIL basic_full2 got %b want 1", hist_full); else n_pass++;
    push(30);
    n_total++; if (D_term !== 15'h0460) $display("FAIL basic_s1 got %h want 0460", D_term); else n_pass++;
    tick();
    n_total++; if (D_term !== 15'h0460 || D_vld !== 1'b1) $display("FAIL basic_s2 got %h/%b want 0460/1", D_term, D_vld); else n_pass++;
    tick();
    n_total++; if (D_vld !== 1'b0) $display("FAIL basic_drop D_vld got %b want 0", D_vld); else n_pass++;
  endtask

  task automatic test_gap();
    // History is {newest 30, oldest 20}; idle cycles must not disturb it.
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (D_vld !== 1'b0 || D_term !== 15'h0460)
        $display("FAIL gap_hold[%0d] got %h/%b want 0460/0", i, D_term, D_vld);
      else n_pass++;
    end
    push(25);   // 25 - 20 = 5  -> 280
    push(40);   // 40 - 30 = 10 -> 560
    n_total++; if (D_term !== 15'h0118) $display("FAIL gap_d5 got %h want 0118", D_term); else n_pass++;
    tick();
    n_total++; if (D_term !== 15'h0230) $display("FAIL gap_d10 got %h want 0230", D_term); else n_pass++;
  endtask

  task automatic test_overflow();
    do_clr();
    push(-1024); push(0); push(1023);
    tick();     // 1023 - (-1024) = 2047 -> 127 * 56
    n_total++; if (D_term !== 15'h1BC8) $display("FAIL pos_sat got %h want 1bc8", D_term); else n_pass++;
    push(1000); push(0); push(-1000);
    tick();     // -1000 - 1000 = -2000 -> -128 * 56
    n_total++; if (D_term !== 15'h6400) $display("FAIL neg_sat got %h want 6400", D_term); else n_pass++;
    do_clr();
    push(127);  // exactly +127, no clamp
    push(-128); // exactly -128, no clamp
    n_total++; if (D_term !== 15'h1BC8) $display("FAIL edge_p127 got %h want 1bc8", D_term); else n_pass++;
    push(128);  // 128 - 127 = 1
    n_total++; if (D_term !== 15'h6400) $display("FAIL edge_m128 got %h want 6400", D_term); else n_pass++;
    tick();
    n_total++; if (D_term !== 15'h0038) $display("FAIL edge_one got %h want 0038", D_term); else n_pass++;
  endtask

  task automatic test_coeff();
    do_clr();
    push(10);   // diff 10
    // Second sample (diff 10) enters while the first diff is multiplied
    // and the new coefficient is written in the same cycle.
    err_sat = 11'sd10; err_vld = 1'b1; coeff_wr = 1'b1; coeff_in = 7'h7F;
    tick();
    err_vld = 1'b0; coeff_wr = 1'b0;
    n_total++; if (D_term !== 15'h0230) $display("FAIL coeff_old got %h want 0230", D_term); else n_pass++;
    push(20);   // 20 - 10 = 10
    n_total++; if (D_term !== 15'h7FF6) $display("FAIL coeff_new got %h want 7ff6", D_term); else n_pass++;
    tick();
    n_total++; if (D_term !== 15'h7FF6) $display("FAIL coeff_new2 got %h want 7ff6", D_term); else n_pass++;
  endtask

  task automatic test_clr();
    push(10);
    // clr coincides with another valid sample; both samples are dropped.
    clr = 1'b1; err_vld = 1'b1; err_sat = 11'sd50;
    tick();
    clr = 1'b0; err_vld = 1'b0;
    n_total++; if (D_term !== 15'h0000 || D_vld !== 1'b0) $display("FAIL clr_out got %h/%b want 0000/0", D_term, D_vld); else n_pass++;
    n_total++; if (hist_full !== 1'b0) $display("FAIL clr_full got %b want 0", hist_full); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (D_vld !== 1'b0) $display("FAIL clr_novld[%0d] got %b want 0", i, D_vld); else n_pass++;
    end
    push(10);
    push(10);   // 2-back still zero: 50 must not have been kept
    n_total++; if (D_term !== 15'h0230 || D_vld !== 1'b1) $display("FAIL clr_next got %h/%b want 0230/1", D_term, D_vld); else n_pass++;
    tick();
    n_total++; if (D_term !== 15'h0230) $display("FAIL clr_next2 got %h want 0230", D_term); else n_pass++;
  endtask

  task automatic test_rst_mid();
    coeff_wr = 1'b1; coeff_in = 7'h7F;
    tick();
    coeff_wr = 1'b0;
    push(30);
    err_sat = 11'sd40; err_vld = 1'b1;
    tick();
    err_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (D_term !== 15'h0000 || D_vld !== 1'b0) $display("FAIL rst_out got %h/%b want 0000/0", D_term, D_vld); else n_pass++;
    n_total++; if (hist_full !== 1'b0) $display("FAIL rst_full got %b want 0", hist_full); else n_pass++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (D_vld !== 1'b0) $display("FAIL rst_novld[%0d] got %b want 0", i, D_vld); else n_pass++;
    end
    push(10);
    tick();     // coefficient is back to +56
    n_total++; if (D_term !== 15'h0230 || D_vld !== 1'b1) $display("FAIL rst_next got %h/%b want 0230/1", D_term, D_vld); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_overflow();
    test_coeff();
    test_clr();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
